// File: rtl/muldiv_ctrl_if.sv
// Handshake bundle between the RV32M sequencing controller and the shared
// iterative multiplier/divider.
interface muldiv_ctrl_if;
  logic        mul_start;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic        mul_done;
  logic [63:0] mul_p;
  logic        div_start;
  logic [31:0] div_n;
  logic [31:0] div_d;
  logic        div_done;
  logic [31:0] div_q;
  logic [31:0] div_r;

  modport master (
    output mul_start, mul_a, mul_b, div_start, div_n, div_d,
    input  mul_done, mul_p, div_done, div_q, div_r
  );

  modport slave (
    input  mul_start, mul_a, mul_b, div_start, div_n, div_d,
    output mul_done, mul_p, div_done, div_q, div_r
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// RV32M EX-stage sequencer: sign handling, unit launch/wait, pipeline stall,
// divide special cases and a one-entry quotient/remainder cache.
module muldiv_ctrl (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ex_valid,
  input  logic [2:0]           funct3,
  input  logic [31:0]          a,
  input  logic [31:0]          b,
  input  logic                 kill,
  output logic                 stall,
  output logic [31:0]          result,
  output logic                 result_valid,
  muldiv_ctrl_if.master        unit
);

  typedef enum logic [2:0] {IDLE, MUL_WAIT, DIV_WAIT, DONE, DRAIN} state_e;

  state_e      state_q, state_d;
  logic [31:0] op_a_q, op_b_q, raw_a_q, raw_b_q;
  logic        sa_q, sb_q;
  logic [2:0]  funct3_q;
  logic [31:0] result_q;
  logic        cache_vld_q, cache_u_q;
  logic [31:0] cache_a_q, cache_b_q, cache_q_q, cache_r_q;

  // Operand decode for the op currently in EX.
  logic        is_div, a_signed, b_signed, sa, sb;
  logic [31:0] mag_a, mag_b;

  assign is_div   = funct3[2];
  assign a_signed = is_div ? ~funct3[0] : (funct3[1:0] != 2'b11);
  assign b_signed = is_div ? ~funct3[0] : ~funct3[1];
  assign sa       = a_signed & a[31];
  assign sb       = b_signed & b[31];
  assign mag_a    = sa ? (~a + 32'd1) : a;
  assign mag_b    = sb ? (~b + 32'd1) : b;

  // Divides that never need the divider.
  logic        div_zero, div_ovf, cache_hit, fast_cond, fast_window, fast_hit, slow_req;
  logic [31:0] fast_q, fast_r, fast_res;

  assign div_zero    = (b == 32'd0);
  assign div_ovf     = ~funct3[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  assign cache_hit   = cache_vld_q && (a == cache_a_q) && (b == cache_b_q) &&
                       (funct3[0] == cache_u_q);
  assign fast_cond   = is_div && (div_zero || div_ovf || cache_hit);
  assign fast_window = (state_q == IDLE) || (state_q == DRAIN);
  assign fast_hit    = !reset && ex_valid && fast_window && fast_cond;
  // A flushed op neither launches nor holds the pipeline.
  assign slow_req    = !reset && ex_valid && !kill && !fast_cond;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and infers a latch.
  always_comb begin
    fast_q = cache_q_q;
    fast_r = cache_r_q;
    if (div_zero) begin
      fast_q = 32'hFFFF_FFFF;
      fast_r = a;
    end else if (div_ovf) begin
      fast_q = a;
      fast_r = 32'd0;
    end
  end

  assign fast_res = funct3[1] ? fast_r : fast_q;

  // Sign restoration on the unit outputs, using the latched sign flags.
  logic [63:0] mul_p_c;
  logic [31:0] div_q_c, div_r_c, mul_res, div_res;

  assign mul_p_c = (sa_q ^ sb_q) ? (~unit.mul_p + 64'd1) : unit.mul_p;
  assign div_q_c = (sa_q ^ sb_q) ? (~unit.div_q + 32'd1) : unit.div_q;
  assign div_r_c = sa_q ? (~unit.div_r + 32'd1) : unit.div_r;
  assign mul_res = (funct3_q[1:0] == 2'b00) ? mul_p_c[31:0] : mul_p_c[63:32];
  assign div_res = funct3_q[1] ? div_r_c : div_q_c;

  logic launch, capture, cache_we, mul_start_c, div_start_c, drain_done;

  assign drain_done = funct3_q[2] ? unit.div_done : unit.mul_done;

  always_comb begin
    state_d      = state_q;
    stall        = 1'b0;
    result_valid = 1'b0;
    result       = 32'd0;
    mul_start_c  = 1'b0;
    div_start_c  = 1'b0;
    launch       = 1'b0;
    capture      = 1'b0;
    cache_we     = 1'b0;
    case (state_q)
      IDLE: begin
        if (slow_req) begin
          launch = 1'b1;
          stall  = 1'b1;
          if (is_div) begin
            div_start_c = 1'b1;
            state_d     = DIV_WAIT;
          end else begin
            mul_start_c = 1'b1;
            state_d     = MUL_WAIT;
          end
        end
      end
      MUL_WAIT: begin
        stall = 1'b1;
        if (kill) begin
          state_d = unit.mul_done ? IDLE : DRAIN;
        end else if (unit.mul_done) begin
          capture = 1'b1;
          state_d = DONE;
        end
      end
      DIV_WAIT: begin
        stall = 1'b1;
        if (kill) begin
          state_d = unit.div_done ? IDLE : DRAIN;
        end else if (unit.div_done) begin
          capture  = 1'b1;
          cache_we = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        result_valid = 1'b1;
        result       = result_q;
        state_d      = IDLE;
      end
      DRAIN: begin
        // A waiting slow op holds EX and launches from IDLE after the drain.
        stall = slow_req;
        if (drain_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (fast_hit) begin
      result_valid = 1'b1;
      result       = fast_res;
    end
  end

  assign unit.mul_start = mul_start_c;
  assign unit.div_start = div_start_c;
  assign unit.mul_a     = launch ? mag_a : op_a_q;
  assign unit.mul_b     = launch ? mag_b : op_b_q;
  assign unit.div_n     = launch ? mag_a : op_a_q;
  assign unit.div_d     = launch ? mag_b : op_b_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      op_a_q      <= 32'd0;
      op_b_q      <= 32'd0;
      raw_a_q     <= 32'd0;
      raw_b_q     <= 32'd0;
      sa_q        <= 1'b0;
      sb_q        <= 1'b0;
      funct3_q    <= 3'd0;
      result_q    <= 32'd0;
      // NOTE: the cache payload is reset along with its valid bit so a
      // stale entry can never be observed after reset.
      cache_vld_q <= 1'b0;
      cache_u_q   <= 1'b0;
      cache_a_q   <= 32'd0;
      cache_b_q   <= 32'd0;
      cache_q_q   <= 32'd0;
      cache_r_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      if (launch) begin
        op_a_q   <= mag_a;
        op_b_q   <= mag_b;
        raw_a_q  <= a;
        raw_b_q  <= b;
        sa_q     <= sa;
        sb_q     <= sb;
        funct3_q <= funct3;
      end
      if (capture) result_q <= funct3_q[2] ? div_res : mul_res;
      if (cache_we) begin
        cache_vld_q <= 1'b1;
        cache_u_q   <= funct3_q[0];
        cache_a_q   <= raw_a_q;
        cache_b_q   <= raw_b_q;
        cache_q_q   <= div_q_c;
        cache_r_q   <= div_r_c;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed scoreboard bench for muldiv_ctrl; the bench plays the role of the
// shared multiplier/divider and supplies its done pulses and results.
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic [2:0]  funct3;
  logic [31:0] a, b;
  logic        kill;
  logic        stall;
  logic [31:0] result;
  logic        result_valid;

  muldiv_ctrl_if u_if ();

  muldiv_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .ex_valid     (ex_valid),
    .funct3       (funct3),
    .a            (a),
    .b            (b),
    .kill         (kill),
    .stall        (stall),
    .result       (result),
    .result_valid (result_valid),
    .unit         (u_if)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] sb_q[$];
  logic [31:0] exp_v;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Result monitor: every valid result consumes the oldest expectation.
  always @(negedge clk) begin
    #2;
    if (result_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_result_valid", result_valid, 1'b0);
      end else begin
        exp_v = sb_q.pop_front();
        check("result", result, exp_v);
      end
    end
  end

  task automatic clear_unit();
    u_if.mul_done = 1'b0;
    u_if.div_done = 1'b0;
    kill          = 1'b0;
  endtask

  task automatic slow_op(input logic [2:0] f3, input logic [31:0] av, input logic [31:0] bv,
                         input int k, input logic [63:0] p, input logic [31:0] q,
                         input logic [31:0] r, input logic [31:0] ex_x,
                         input logic [31:0] ex_y, input logic [31:0] ex_res);
    int stalls;
    stalls = 0;
    @(negedge clk);
    clear_unit();
    ex_valid = 1'b1; funct3 = f3; a = av; b = bv;
    sb_q.push_back(ex_res);
    #1;
    if (f3[2]) begin
      check("div_start", u_if.div_start, 1'b1);
      check("div_n", u_if.div_n, ex_x);
      check("div_d", u_if.div_d, ex_y);
    end else begin
      check("mul_start", u_if.mul_start, 1'b1);
      check("mul_a", u_if.mul_a, ex_x);
      check("mul_b", u_if.mul_b, ex_y);
    end
    stalls += int'(stall);
    for (int c = 1; c <= k; c++) begin
      @(negedge clk);
      if (c == k) begin
        if (f3[2]) begin
          u_if.div_done = 1'b1; u_if.div_q = q; u_if.div_r = r;
        end else begin
          u_if.mul_done = 1'b1; u_if.mul_p = p;
        end
      end
      #1;
      check("start_single_pulse", {u_if.mul_start, u_if.div_start}, 2'b00);
      check("held_operand", f3[2] ? u_if.div_n : u_if.mul_a, ex_x);
      stalls += int'(stall);
    end
    @(negedge clk);
    clear_unit();
    #1;
    check("done_stall", stall, 1'b0);
    check("stall_cycles", stalls, k + 1);
  endtask

  task automatic fast_op(input logic [2:0] f3, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] ex_res);
    @(negedge clk);
    clear_unit();
    ex_valid = 1'b1; funct3 = f3; a = av; b = bv;
    sb_q.push_back(ex_res);
    #1;
    check("fast_stall", stall, 1'b0);
    check("fast_no_start", {u_if.mul_start, u_if.div_start}, 2'b00);
    check("fast_valid", result_valid, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; ex_valid = 1'b0; funct3 = 3'd0; a = 32'd0; b = 32'd0; kill = 1'b0;
    u_if.mul_done = 1'b0; u_if.mul_p = 64'd0;
    u_if.div_done = 1'b0; u_if.div_q = 32'd0; u_if.div_r = 32'd0;
    @(negedge clk);
    #1;
    check("rst_stall", stall, 1'b0);
    check("rst_valid", result_valid, 1'b0);
    check("rst_starts", {u_if.mul_start, u_if.div_start}, 2'b00);
    check("rst_result", result, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Multiplies: sign handling and high/low word selection.
    slow_op(3'b000, 32'd7, 32'hFFFF_FFFD, 3, 64'd21, 0, 0, 32'd7, 32'd3, 32'hFFFF_FFEB);
    slow_op(3'b001, 32'h8000_0000, 32'h8000_0000, 2, 64'h4000_0000_0000_0000, 0, 0,
            32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    slow_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 64'hFFFF_FFFE_0000_0001, 0, 0,
            32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    slow_op(3'b010, 32'hFFFF_FFFF, 32'd2, 1, 64'd2, 0, 0, 32'd1, 32'd2, 32'hFFFF_FFFF);

    // Divide, cached remainder, then an unsigned miss on the same operands.
    slow_op(3'b100, 32'hFFFF_FFF9, 32'd2, 4, 0, 32'd3, 32'd1, 32'd7, 32'd2, 32'hFFFF_FFFD);
    fast_op(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    slow_op(3'b111, 32'hFFFF_FFF9, 32'd2, 2, 0, 32'h7FFF_FFFC, 32'd1,
            32'hFFFF_FFF9, 32'd2, 32'd1);

    // Divide-by-zero and signed overflow.
    fast_op(3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF);
    fast_op(3'b111, 32'd5, 32'd0, 32'd5);
    fast_op(3'b110, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9);
    fast_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    fast_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

    // Kill in DIV_WAIT, then a DIV waiting in DRAIN.
    @(negedge clk);
    clear_unit();
    ex_valid = 1'b1; funct3 = 3'b100; a = 32'd100; b = 32'd7;
    #1;
    check("kill_div_start", u_if.div_start, 1'b1);
    @(negedge clk);
    kill = 1'b1; ex_valid = 1'b0;
    #1;
    check("kill_cycle_stall", stall, 1'b1);
    @(negedge clk);
    kill = 1'b0;
    #1;
    check("drain_idle_stall", stall, 1'b0);
    for (int c = 3; c <= 7; c++) begin
      @(negedge clk);
      ex_valid = 1'b1; funct3 = 3'b100; a = 32'd50; b = 32'd5;
      if (c == 7) begin
        u_if.div_done = 1'b1; u_if.div_q = 32'hDEAD; u_if.div_r = 32'hBEEF;
      end
      #1;
      check("drain_wait_stall", stall, 1'b1);
      check("drain_no_start", u_if.div_start, 1'b0);
    end
    slow_op(3'b100, 32'd50, 32'd5, 2, 0, 32'd10, 32'd0, 32'd50, 32'd5, 32'd10);
    // The killed 100/7 must not have been cached.
    slow_op(3'b110, 32'd100, 32'd7, 2, 0, 32'd14, 32'd2, 32'd100, 32'd7, 32'd2);

    // Done coinciding with kill returns straight to IDLE.
    @(negedge clk);
    clear_unit();
    ex_valid = 1'b1; funct3 = 3'b000; a = 32'd2; b = 32'd3;
    #1;
    check("dk_mul_start", u_if.mul_start, 1'b1);
    @(negedge clk);
    kill = 1'b1; ex_valid = 1'b0; u_if.mul_done = 1'b1; u_if.mul_p = 64'd6;
    #1;
    check("dk_stall", stall, 1'b1);
    slow_op(3'b000, 32'd4, 32'd5, 1, 64'd20, 0, 0, 32'd4, 32'd5, 32'd20);

    // Asynchronous reset mid MUL_WAIT.
    @(negedge clk);
    clear_unit();
    ex_valid = 1'b1; funct3 = 3'b000; a = 32'd3; b = 32'd5;
    #1;
    check("rw_mul_start", u_if.mul_start, 1'b1);
    @(negedge clk);
    #1;
    check("rw_wait_stall", stall, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rw_stall", stall, 1'b0);
    check("rw_result", result, 32'd0);
    check("rw_starts", {u_if.mul_start, u_if.div_start}, 2'b00);
    check("rw_valid", result_valid, 1'b0);
    @(negedge clk);
    reset = 1'b0; ex_valid = 1'b0; u_if.mul_done = 1'b1; u_if.mul_p = 64'hFF;
    #1;
    check("stale_done_stall", stall, 1'b0);
    @(negedge clk);
    u_if.mul_done = 1'b0;
    #1;
    check("stale_done_valid", result_valid, 1'b0);
    slow_op(3'b000, 32'd3, 32'd5, 2, 64'd15, 0, 0, 32'd3, 32'd5, 32'd15);
    // Reset also invalidated the cache holding REM 100/7.
    slow_op(3'b110, 32'd100, 32'd7, 1, 0, 32'd14, 32'd2, 32'd100, 32'd7, 32'd2);

    @(negedge clk);
    ex_valid = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    check("scoreboard_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
